bt_cmd_decoder: RTL and testbench

// Downstream stage of the Bluetooth UART receiver. Takes each received byte
// (with a one-cycle valid strobe), decodes ASCII game commands and buffers

---
 rtl/bt_cmd_decoder.sv | 143 ++++++++++++++
 tb/tb_bt_cmd_decoder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/bt_cmd_decoder.sv
// Decodes UART command bytes into queued direction changes, pause/restart and link status.
// Latency: 1 cycle from rx_valid/step to every output; no backpressure, overflowing pushes are dropped and flagged.
module bt_cmd_decoder #(
    parameter int FIFO_DEPTH   = 4,
    parameter int LINK_TIMEOUT = 100_000_000,
    parameter int CNT_W        = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       step,
    output logic [1:0] dir,
    output logic       pause,
    output logic       restart_pulse,
    output logic       cmd_err,
    output logic       fifo_full,
    output logic       link_alive
);

    localparam int               PW        = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]      DEPTH_C   = (PW+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(LINK_TIMEOUT);

    logic [1:0]       mem_q [FIFO_DEPTH];
    logic [1:0]       mem_d [FIFO_DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [1:0]       dir_q, dir_d;
    logic             pause_q, pause_d;
    logic             restart_pulse_q, restart_pulse_d;
    logic             cmd_err_q, cmd_err_d;
    logic [CNT_W-1:0] link_cnt_q, link_cnt_d;

    logic       is_dir, is_pause, is_restart;
    logic [1:0] dir_code;
    logic [7:0] upper;
    logic       pop, push_req, push_ok;
    logic [1:0] head;

    // Clearing bit 5 folds lowercase letters onto uppercase; no other byte aliases a command.
    always_comb begin
        upper      = rx_data & 8'hDF;
        is_dir     = 1'b0;
        is_pause   = 1'b0;
        is_restart = 1'b0;
        dir_code   = 2'b00;
        case (upper)
            8'h57:   begin is_dir = 1'b1; dir_code = 2'b00; end
            8'h53:   begin is_dir = 1'b1; dir_code = 2'b01; end
            8'h41:   begin is_dir = 1'b1; dir_code = 2'b10; end
            8'h44:   begin is_dir = 1'b1; dir_code = 2'b11; end
            8'h50:   is_pause   = 1'b1;
            8'h52:   is_restart = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        head     = mem_q[rd_ptr_q];
        pop      = step && !pause_q && (count_q != '0);
        push_req = rx_valid && is_dir;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
        push_ok  = push_req && ((count_q != DEPTH_C) || pop);

        mem_d           = mem_q;
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        count_d         = count_q;
        dir_d           = dir_q;
        pause_d         = pause_q;
        restart_pulse_d = 1'b0;
        cmd_err_d       = 1'b0;

        if (rx_valid)
            link_cnt_d = '0;
        else if (link_cnt_q < TIMEOUT_C)
            link_cnt_d = link_cnt_q + CNT_W'(1);
        else
            link_cnt_d = link_cnt_q;

        if (rx_valid && is_restart) begin
            rd_ptr_d        = '0;
            wr_ptr_d        = '0;
            count_d         = '0;
            dir_d           = 2'b11;
            pause_d         = 1'b0;
            restart_pulse_d = 1'b1;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                // Opposite directions differ only in bit 0.
                if ((head ^ dir_q) != 2'b01)
                    dir_d = head;
            end
            if (push_ok) begin
                mem_d[wr_ptr_q] = dir_code;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
            if (rx_valid && is_pause)
                pause_d = !pause_q;
            cmd_err_d = rx_valid && !is_pause && (!is_dir || !push_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 2'b00;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            count_q         <= '0;
            dir_q           <= 2'b11;
            pause_q         <= 1'b0;
            restart_pulse_q <= 1'b0;
            cmd_err_q       <= 1'b0;
            link_cnt_q      <= TIMEOUT_C;
        end else begin
            mem_q           <= mem_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
            dir_q           <= dir_d;
            pause_q         <= pause_d;
            restart_pulse_q <= restart_pulse_d;
            cmd_err_q       <= cmd_err_d;
            link_cnt_q      <= link_cnt_d;
        end
    end

    assign dir           = dir_q;
    assign pause         = pause_q;
    assign restart_pulse = restart_pulse_q;
    assign cmd_err       = cmd_err_q;
    assign fifo_full     = (count_q == DEPTH_C);
    assign link_alive    = (link_cnt_q < TIMEOUT_C);

endmodule

// File: tb/tb_bt_cmd_decoder.sv
// Directed bench for bt_cmd_decoder: each step queues its expected outputs, checked one cycle later.
module tb_bt_cmd_decoder;

    localparam int TO = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       step = 1'b0;
    logic [1:0] dir;
    logic       pause, restart_pulse, cmd_err, fifo_full, link_alive;

    typedef struct packed {
        logic [1:0] dir;
        logic       pause;
        logic       rp;
        logic       err;
        logic       full;
        logic       alive;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   idle  = TO;

    bt_cmd_decoder #(.FIFO_DEPTH(4), .LINK_TIMEOUT(TO), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .step(step),
        .dir(dir), .pause(pause), .restart_pulse(restart_pulse), .cmd_err(cmd_err),
        .fifo_full(fifo_full), .link_alive(link_alive)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic s,
                       input logic [1:0] edir, input logic ep, input logic erp,
                       input logic eerr, input logic efull);
        exp_t e, got;
        rst = r; rx_valid = v; rx_data = d; step = s;
        if (r)                idle = TO;
        else if (v)           idle = 0;
        else if (idle < TO)   idle = idle + 1;
        e = '{dir: edir, pause: ep, rp: erp, err: eerr, full: efull, alive: (idle < TO)};
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        tests++;
        assert (dir === got.dir) else begin
            fails++; $error("FAIL dir: got %b expected %b", dir, got.dir);
        end
        tests++;
        assert (pause === got.pause) else begin
            fails++; $error("FAIL pause: got %b expected %b", pause, got.pause);
        end
        tests++;
        assert (restart_pulse === got.rp) else begin
            fails++; $error("FAIL restart_pulse: got %b expected %b", restart_pulse, got.rp);
        end
        tests++;
        assert (cmd_err === got.err) else begin
            fails++; $error("FAIL cmd_err: got %b expected %b", cmd_err, got.err);
        end
        tests++;
        assert (fifo_full === got.full) else begin
            fails++; $error("FAIL fifo_full: got %b expected %b", fifo_full, got.full);
        end
        tests++;
        assert (link_alive === got.alive) else begin
            fails++; $error("FAIL link_alive: got %b expected %b", link_alive, got.alive);
        end
    endtask

    initial begin
        // reset values
        cyc(1, 0, 8'h00, 0,  2'b11, 0, 0, 0, 0);
        cyc(1, 1, 8'h77, 1,  2'b11, 0, 0, 0, 0);

        // 'w' then step: right -> up; extra step on empty FIFO holds dir
        cyc(0, 1, 8'h77, 0,  2'b11, 0, 0, 0, 0);
        cyc(0, 0, 8'h00, 1,  2'b00, 0, 0, 0, 0);
        cyc(0, 0, 8'h00, 1,  2'b00, 0, 0, 0, 0);
        cyc(0, 1, 8'h64, 0,  2'b00, 0, 0, 0, 0);
        cyc(0, 0, 8'h00, 1,  2'b11, 0, 0, 0, 0);

        // 'a' is a reversal of right and is discarded, 's' then applies
        cyc(0, 1, 8'h61, 0,  2'b11, 0, 0, 0, 0);
        cyc(0, 1, 8'h73, 0,  2'b11, 0, 0, 0, 0);
        cyc(0, 0, 8'h00, 1,  2'b11, 0, 0, 0, 0);
        cyc(0, 0, 8'h00, 1,  2'b01, 0, 0, 0, 0);

        // five 'd' without steps: full after four, fifth overflows
        cyc(0, 1, 8'h64, 0,  2'b01, 0, 0, 0, 0);
        cyc(0, 1, 8'h64, 0,  2'b01, 0, 0, 0, 0);
        cyc(0, 1, 8'h64, 0,  2'b01, 0, 0, 0, 0);
        cyc(0, 1, 8'h64, 0,  2'b01, 0, 0, 0, 1);
        cyc(0, 1, 8'h64, 0,  2'b01, 0, 0, 1, 1);
        cyc(0, 0, 8'h00, 0,  2'b01, 0, 0, 0, 1);
        cyc(0, 0, 8'h00, 1,  2'b11, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 8'h00, 1,  2'b11, 0, 0, 0, 0);

        // pause blocks pops; 'P' resumes
        cyc(0, 1, 8'h70, 0,  2'b11, 1, 0, 0, 0);
        cyc(0, 1, 8'h77, 0,  2'b11, 1, 0, 0, 0);
        cyc(0, 0, 8'h00, 1,  2'b11, 1, 0, 0, 0);
        cyc(0, 1, 8'h50, 0,  2'b11, 0, 0, 0, 0);
        cyc(0, 0, 8'h00, 1,  2'b00, 0, 0, 0, 0);

        // push and step together on an empty FIFO: entry stays queued
        cyc(0, 1, 8'h61, 1,  2'b00, 0, 0, 0, 0);
        cyc(0, 0, 8'h00, 1,  2'b10, 0, 0, 0, 0);

        // restart beats the step: flush, dir right, unpause
        cyc(0, 1, 8'h57, 0,  2'b10, 0, 0, 0, 0);
        cyc(0, 1, 8'h41, 0,  2'b10, 0, 0, 0, 0);
        cyc(0, 1, 8'h70, 0,  2'b10, 1, 0, 0, 0);
        cyc(0, 1, 8'h72, 1,  2'b11, 0, 1, 0, 0);
        cyc(0, 0, 8'h00, 0,  2'b11, 0, 0, 0, 0);
        cyc(0, 0, 8'h00, 1,  2'b11, 0, 0, 0, 0);
        cyc(0, 1, 8'h78, 0,  2'b11, 0, 0, 1, 0);
        cyc(0, 0, 8'h00, 0,  2'b11, 0, 0, 0, 0);

        // full FIFO with push and pop in the same cycle: push accepted
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 8'h57, 0,  2'b11, 0, 0, 0, 0);
        cyc(0, 1, 8'h57, 0,  2'b11, 0, 0, 0, 1);
        cyc(0, 1, 8'h44, 1,  2'b00, 0, 0, 0, 1);
        cyc(0, 0, 8'h00, 1,  2'b00, 0, 0, 0, 0);
        cyc(0, 0, 8'h00, 1,  2'b00, 0, 0, 0, 0);
        cyc(0, 0, 8'h00, 1,  2'b00, 0, 0, 0, 0);
        cyc(0, 0, 8'h00, 1,  2'b11, 0, 0, 0, 0);

        // moving down with "up,left" queued ends up left
        cyc(0, 1, 8'h53, 1,  2'b11, 0, 0, 0, 0);
        cyc(0, 0, 8'h00, 1,  2'b01, 0, 0, 0, 0);
        cyc(0, 1, 8'h77, 0,  2'b01, 0, 0, 0, 0);
        cyc(0, 1, 8'h61, 0,  2'b01, 0, 0, 0, 0);
        cyc(0, 0, 8'h00, 1,  2'b01, 0, 0, 0, 0);
        cyc(0, 0, 8'h00, 1,  2'b10, 0, 0, 0, 0);

        // link_alive drops after the idle timeout
        for (int i = 0; i < TO + 2; i++)
            cyc(0, 0, 8'h00, 0,  2'b10, 0, 0, 0, 0);

        // reset mid-operation loses queued commands and pause, no restart pulse
        cyc(0, 1, 8'h77, 0,  2'b10, 0, 0, 0, 0);
        cyc(0, 1, 8'h70, 0,  2'b10, 1, 0, 0, 0);
        cyc(1, 0, 8'h00, 0,  2'b11, 0, 0, 0, 0);
        cyc(0, 0, 8'h00, 1,  2'b11, 0, 0, 0, 0);
        cyc(0, 0, 8'h00, 0,  2'b11, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
